apb3_timer: RTL

- 32-bit down-counting timer, APB3 slave.
- Sits directly downstream of the AHB-to-APB3 bridge and consumes its PSEL/PENABLE/PADDR/PWRITE/PWDATA access stream.
- Returns PRDATA/PREADY/PSLVERR to the bridge and drives a level interrupt to the processor.
- Registers: LOAD, VALUE, CTRL, PRESCALE, RIS, MIS.

---
 rtl/apb3_timer_if.sv | 23 ++
 rtl/apb3_timer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/apb3_timer_if.sv
// rtl/apb3_timer_if.sv - APB3 bus bundle between the bridge (master) and the timer (slave)
interface apb3_timer_if #(
  parameter int ADDR_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb3_timer.sv
// rtl/apb3_timer.sv - 32-bit prescaled down-counting timer with APB3 register access
module apb3_timer #(
  parameter int ADDR_W     = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic         PCLK,
  input  logic         PRESETN,
  apb3_timer_if.slave  apb,
  output logic         TIMINT
);

  localparam logic [7:0] A_LOAD     = 8'h00;
  localparam logic [7:0] A_VALUE    = 8'h04;
  localparam logic [7:0] A_CTRL     = 8'h08;
  localparam logic [7:0] A_PRESCALE = 8'h0C;
  localparam logic [7:0] A_RIS      = 8'h10;
  localparam logic [7:0] A_MIS      = 8'h14;

  logic [31:0]           load_q, load_d;
  logic [31:0]           value_q, value_d;
  logic                  en_q, en_d;
  logic                  ie_q, ie_d;
  logic                  oneshot_q, oneshot_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  ris_q, ris_d;

  logic [7:0]  addr;
  logic        acc;
  logic        addr_ok;
  logic        wr;
  logic        load_wr;
  logic        tick;
  logic        tick_eff;
  logic [31:0] rdata;
  logic        unused_bits;

  assign addr        = apb.PADDR[7:0];
  assign acc         = apb.PSEL & apb.PENABLE;
  assign addr_ok     = (addr < 8'h18) && (addr[1:0] == 2'b00);
  assign wr          = acc & apb.PWRITE & addr_ok;
  assign load_wr     = wr && (addr == A_LOAD);
  assign tick        = en_q && (pcnt_q == prescale_q);
  // A LOAD write swallows a coincident tick entirely, including its RIS set
  assign tick_eff    = tick & ~load_wr;
  assign unused_bits = &{1'b0, apb.PADDR, apb.PWDATA};

  always_comb begin
    load_d     = load_q;
    value_d    = value_q;
    en_d       = en_q;
    ie_d       = ie_q;
    oneshot_d  = oneshot_q;
    prescale_d = prescale_q;
    pcnt_d     = (en_q && !tick) ? pcnt_q + PRESCALE_W'(1) : '0;
    ris_d      = ris_q;

    if (wr && addr == A_RIS && apb.PWDATA[0]) begin
      ris_d = 1'b0;
    end

    if (load_wr) begin
      load_d  = apb.PWDATA;
      value_d = apb.PWDATA;
      pcnt_d  = '0;
    end else if (tick_eff) begin
      if (value_q != 32'd0) begin
        value_d = value_q - 32'd1;
      end else begin
        ris_d = 1'b1;
        if (oneshot_q) begin
          en_d = 1'b0;
        end else begin
          value_d = load_q;
        end
      end
    end

    if (wr && addr == A_CTRL) begin
      en_d      = apb.PWDATA[0];
      ie_d      = apb.PWDATA[1];
      oneshot_d = apb.PWDATA[2];
    end

    if (wr && addr == A_PRESCALE) begin
      prescale_d = apb.PWDATA[PRESCALE_W-1:0];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      load_q     <= '0;
      value_q    <= '0;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      oneshot_q  <= 1'b0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      ris_q      <= 1'b0;
    end else begin
      load_q     <= load_d;
      value_q    <= value_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      oneshot_q  <= oneshot_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      ris_q      <= ris_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (acc && !apb.PWRITE && addr_ok) begin
      case (addr)
        A_LOAD:     rdata = load_q;
        A_VALUE:    rdata = value_q;
        A_CTRL:     rdata = {29'd0, oneshot_q, ie_q, en_q};
        A_PRESCALE: rdata = 32'(prescale_q);
        A_RIS:      rdata = {31'd0, ris_q};
        A_MIS:      rdata = {31'd0, ris_q & ie_q};
        default:    rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = 1'b1;
  // Gated by reset so the error response drops the instant reset asserts
  assign apb.PSLVERR = PRESETN & acc & ~addr_ok;
  assign TIMINT      = ris_q & ie_q;

endmodule
